// File: rtl/uart_job_sequencer_if.sv
// Stream and status bundle between the UART receiver, the job sequencer and the
// puzzle solver.
//   master : the sequencer (takes rx bytes and sol_ready, drives the solver stream and status)
//   slave  : the environment around it (UART receiver, solver, 7-segment logic)
// Signals:
//   rx_byte/rx_valid       received byte and its one-cycle strobe
//   sol_byte/sol_valid     FIFO head byte offered to the solver
//   sol_ready              solver accepts sol_byte
//   sol_start/sol_end      one-cycle job framing pulses
//   done/busy/overflow     job status flags
//   byte_count             bytes accepted into the FIFO in the current job
interface uart_job_sequencer_if #(
    parameter int COUNT_W = 16
);
    logic [7:0]         rx_byte;
    logic               rx_valid;
    logic [7:0]         sol_byte;
    logic               sol_valid;
    logic               sol_ready;
    logic               sol_start;
    logic               sol_end;
    logic               done;
    logic               busy;
    logic               overflow;
    logic [COUNT_W-1:0] byte_count;

    modport master (
        input  rx_byte, rx_valid, sol_ready,
        output sol_byte, sol_valid, sol_start, sol_end, done, busy, overflow, byte_count
    );

    modport slave (
        output rx_byte, rx_valid, sol_ready,
        input  sol_byte, sol_valid, sol_start, sol_end, done, busy, overflow, byte_count
    );
endinterface

// File: rtl/uart_job_sequencer.sv
// Frames UART bytes into solver jobs. Bytes go through a first-word-fall-through
// FIFO to the solver stream; a job begins with the first byte seen while idle and
// ends once the line has been quiet for IDLE_TIMEOUT cycles and the FIFO has drained.
// Ports:
//   CLK     system clock
//   RST_N   asynchronous active-low reset
//   seq_if  uart_job_sequencer_if.master (rx input, solver stream, status)
//
// state   | meaning
// --------+-----------------------------------------------------------------
// S_IDLE  | no job since reset, waiting for the first byte
// S_RECV  | job open, bytes arriving, idle timer counting quiet cycles
// S_DRAIN | line went quiet, waiting for the solver to empty the FIFO
// S_DONE  | job finished, done held high until the next first byte
module uart_job_sequencer #(
    parameter int FIFO_DEPTH   = 16,
    parameter int IDLE_TIMEOUT = 21700,
    parameter int COUNT_W      = 16
) (
    input  logic                  CLK,
    input  logic                  RST_N,
    uart_job_sequencer_if.master  seq_if
);
    localparam int PTR_W = $clog2(FIFO_DEPTH);
    localparam int TMR_W = $clog2(IDLE_TIMEOUT + 1);
    localparam logic [TMR_W-1:0] TMR_LAST = TMR_W'(IDLE_TIMEOUT - 1);
    localparam logic [PTR_W:0]   PTR_ONE  = (PTR_W+1)'(1);

    typedef enum logic [1:0] {S_IDLE, S_RECV, S_DRAIN, S_DONE} state_t;

    state_t               state_q, state_d;
    logic [7:0]           mem_q [FIFO_DEPTH];
    logic [PTR_W:0]       wr_ptr_q, rd_ptr_q;
    logic [TMR_W-1:0]     tmr_q, tmr_d;
    logic                 sol_start_q, sol_start_d;
    logic                 sol_end_q, sol_end_d;
    logic                 done_q, done_d;
    logic                 ovf_q, ovf_d;
    logic [COUNT_W-1:0]   cnt_q, cnt_d;

    logic empty, full, sol_valid, pop, push;

    // Extra pointer bit distinguishes full from empty when the indices match.
    assign empty = (wr_ptr_q == rd_ptr_q);
    assign full  = (wr_ptr_q[PTR_W] != rd_ptr_q[PTR_W]) &&
                   (wr_ptr_q[PTR_W-1:0] == rd_ptr_q[PTR_W-1:0]);

    // The head byte is held back during the sol_start cycle so the solver
    // clears its accumulators before seeing data.
    assign sol_valid = !empty && !sol_start_q;
    assign pop       = sol_valid && seq_if.sol_ready;
    // A full FIFO still takes a byte when the head leaves in the same cycle.
    assign push      = seq_if.rx_valid && (!full || pop);

    always_ff @(posedge CLK) begin
        if (push) begin
            mem_q[wr_ptr_q[PTR_W-1:0]] <= seq_if.rx_byte;
        end
    end

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
        end else begin
            if (push) wr_ptr_q <= wr_ptr_q + PTR_ONE;
            if (pop)  rd_ptr_q <= rd_ptr_q + PTR_ONE;
        end
    end

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            state_q     <= S_IDLE;
            tmr_q       <= '0;
            sol_start_q <= 1'b0;
            sol_end_q   <= 1'b0;
            done_q      <= 1'b0;
            ovf_q       <= 1'b0;
            cnt_q       <= '0;
        end else begin
            state_q     <= state_d;
            tmr_q       <= tmr_d;
            sol_start_q <= sol_start_d;
            sol_end_q   <= sol_end_d;
            done_q      <= done_d;
            ovf_q       <= ovf_d;
            cnt_q       <= cnt_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        tmr_d       = tmr_q;
        sol_start_d = 1'b0;
        sol_end_d   = 1'b0;
        done_d      = done_q;
        ovf_d       = ovf_q;
        cnt_d       = cnt_q;

        case (state_q)
            S_IDLE, S_DONE: begin
                if (seq_if.rx_valid) begin
                    sol_start_d = 1'b1;
                    ovf_d       = 1'b0;
                    cnt_d       = COUNT_W'(1);
                    done_d      = 1'b0;
                    tmr_d       = '0;
                    state_d     = S_RECV;
                end
            end
            S_RECV: begin
                // A byte on the timeout cycle keeps the job open.
                if (seq_if.rx_valid) begin
                    tmr_d = '0;
                end else if (tmr_q == TMR_LAST) begin
                    state_d = S_DRAIN;
                end else begin
                    tmr_d = tmr_q + TMR_W'(1);
                end
            end
            S_DRAIN: begin
                // Timer is frozen here; a stalled solver just keeps us waiting.
                if (seq_if.rx_valid) begin
                    tmr_d   = '0;
                    state_d = S_RECV;
                end else if (empty) begin
                    sol_end_d = 1'b1;
                    done_d    = 1'b1;
                    state_d   = S_DONE;
                end
            end
            default: state_d = S_IDLE;
        endcase

        if ((state_q == S_RECV || state_q == S_DRAIN) && seq_if.rx_valid) begin
            if (push) begin
                if (cnt_q != '1) cnt_d = cnt_q + COUNT_W'(1);
            end else begin
                ovf_d = 1'b1;
            end
        end
    end

    assign seq_if.sol_byte   = empty ? 8'h00 : mem_q[rd_ptr_q[PTR_W-1:0]];
    assign seq_if.sol_valid  = sol_valid;
    assign seq_if.sol_start  = sol_start_q;
    assign seq_if.sol_end    = sol_end_q;
    assign seq_if.done       = done_q;
    assign seq_if.busy       = (state_q == S_RECV) || (state_q == S_DRAIN);
    assign seq_if.overflow   = ovf_q;
    assign seq_if.byte_count = cnt_q;
endmodule

// File: tb/tb_uart_job_sequencer.sv
`timescale 1ns/100ps
module tb_uart_job_sequencer;
    localparam int DEPTH = 16;
    localparam int T     = 40;
    localparam int CW    = 16;
    localparam int MAXC  = (1 << CW) - 1;

    logic CLK   = 1'b0;
    logic RST_N = 1'b0;
    always #5 CLK = ~CLK;

    uart_job_sequencer_if #(.COUNT_W(CW)) bus ();

    uart_job_sequencer #(
        .FIFO_DEPTH  (DEPTH),
        .IDLE_TIMEOUT(T),
        .COUNT_W     (CW)
    ) dut (
        .CLK   (CLK),
        .RST_N (RST_N),
        .seq_if(bus.master)
    );

    int checks = 0;
    int errors = 0;

    // Reference model: FIFO contents as a queue, occupancy, current job totals.
    logic [7:0] exp_q[$];
    int  m_occ = 0;
    bit  m_start = 1'b0;
    int  m_count = 0;
    bit  m_ovf = 1'b0;
    int  jobs_started = 0;
    int  jobs_ended = 0;
    int  cyc = 0;
    int  last_rx_cyc = 0;
    int  end_cyc = 0;
    int  starts_seen = 0;
    bit  end_allowed = 1'b0;
    bit  pop_now, start_now;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic send(input logic [7:0] b);
        bus.rx_byte  = b;
        bus.rx_valid = 1'b1;
        tick();
        bus.rx_valid = 1'b0;
    endtask

    task automatic idle(input int n);
        repeat (n) tick();
    endtask

    task automatic wait_end(input int bound, input bit rand_ready);
        int e0 = jobs_ended;
        int k = 0;
        end_allowed = 1'b1;
        while (jobs_ended == e0 && k < bound) begin
            if (rand_ready) bus.sol_ready = 1'($urandom_range(0, 1));
            tick();
            k++;
        end
        end_allowed = 1'b0;
        chk("job_end_seen", jobs_ended - e0, 1);
        chk("done_after_end", bus.done, 1'b1);
        chk("busy_after_end", bus.busy, 1'b0);
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, "_sol_byte"},   bus.sol_byte, 0);
        chk({tag, "_sol_valid"},  bus.sol_valid, 0);
        chk({tag, "_sol_start"},  bus.sol_start, 0);
        chk({tag, "_sol_end"},    bus.sol_end, 0);
        chk({tag, "_done"},       bus.done, 0);
        chk({tag, "_busy"},       bus.busy, 0);
        chk({tag, "_overflow"},   bus.overflow, 0);
        chk({tag, "_byte_count"}, bus.byte_count, 0);
    endtask

    initial begin
        int s0, n, gap;
        bus.rx_byte   = 8'h00;
        bus.rx_valid  = 1'b0;
        bus.sol_ready = 1'b0;
        fork
            // model: updates expectations on every sampling edge
            forever begin
                @(posedge CLK or negedge RST_N);
                if (!RST_N) begin
                    exp_q.delete();
                    m_occ = 0;
                    m_start = 1'b0;
                    m_count = 0;
                    m_ovf = 1'b0;
                    jobs_started = jobs_ended;
                end else begin
                    cyc++;
                    pop_now = (m_occ > 0) && bus.sol_ready && !m_start;
                    start_now = 1'b0;
                    if (bus.rx_valid) begin
                        last_rx_cyc = cyc;
                        if (jobs_started == jobs_ended) begin
                            jobs_started++;
                            m_count = 1;
                            m_ovf = 1'b0;
                            exp_q.push_back(bus.rx_byte);
                            m_occ++;
                            start_now = 1'b1;
                        end else if (m_occ < DEPTH || pop_now) begin
                            exp_q.push_back(bus.rx_byte);
                            m_occ++;
                            if (m_count < MAXC) m_count++;
                        end else begin
                            m_ovf = 1'b1;
                        end
                    end
                    if (pop_now) m_occ--;
                    m_start = start_now;
                end
            end
            // monitor: compares whatever the DUT presents
            forever begin
                @(negedge CLK or negedge RST_N);
                if (RST_N) begin
                    if (bus.sol_valid && bus.sol_ready) begin
                        chk("byte_pending", exp_q.size() > 0, 1'b1);
                        if (exp_q.size() > 0) chk("sol_byte", bus.sol_byte, exp_q.pop_front());
                    end
                    if (bus.sol_start) begin
                        starts_seen++;
                        chk("start_done",  bus.done, 0);
                        chk("start_count", bus.byte_count, 1);
                        chk("start_ovf",   bus.overflow, 0);
                        chk("start_valid", bus.sol_valid, 0);
                    end
                    if (bus.sol_end) begin
                        chk("end_expected", end_allowed, 1'b1);
                        chk("end_valid",    bus.sol_valid, 0);
                        chk("end_drained",  exp_q.size(), 0);
                        chk("end_count",    bus.byte_count, m_count);
                        chk("end_ovf",      bus.overflow, m_ovf);
                        chk("end_done",     bus.done, 1'b1);
                        end_cyc = cyc;
                        jobs_ended++;
                    end
                end
            end
            // stimulus
            begin
                #3;
                chk_all_zero("reset");
                idle(3);
                RST_N = 1'b1;
                tick();

                // three-byte job
                bus.sol_ready = 1'b1;
                s0 = starts_seen;
                send(8'h28);
                send(8'h28);
                send(8'h29);
                wait_end(T + 10, 1'b0);
                chk("job1_latency", (end_cyc - last_rx_cyc >= T + 1) && (end_cyc - last_rx_cyc <= T + 3), 1'b1);
                chk("job1_starts", starts_seen - s0, 1);
                chk("job1_count", bus.byte_count, 3);
                chk("job1_ovf", bus.overflow, 0);

                // back-pressure overflow: 20 strobes into 16 entries
                bus.sol_ready = 1'b0;
                for (int i = 0; i < 20; i++) send(8'($urandom));
                chk("ovf_flag", bus.overflow, 1);
                chk("ovf_count", bus.byte_count, 16);
                idle(T + 5);
                chk("ovf_drain_wait_busy", bus.busy, 1);
                bus.sol_ready = 1'b1;
                wait_end(T + 60, 1'b0);

                // full FIFO with a simultaneous pop accepts the byte
                bus.sol_ready = 1'b0;
                for (int i = 0; i < DEPTH; i++) send(8'(8'h40 + i));
                bus.sol_ready = 1'b1;
                send(8'hA5);
                bus.sol_ready = 1'b0;
                chk("fullpop_count", bus.byte_count, 17);
                chk("fullpop_ovf", bus.overflow, 0);
                send(8'h5A);
                chk("still_full_ovf", bus.overflow, 1);
                chk("still_full_count", bus.byte_count, 17);
                idle(T + 2);
                bus.sol_ready = 1'b1;
                wait_end(T + 60, 1'b0);

                // second job clears status from the previous one
                s0 = starts_seen;
                send(8'h29);
                chk("job2_sol_start", bus.sol_start, 1);
                chk("job2_done", bus.done, 0);
                chk("job2_count", bus.byte_count, 1);
                chk("job2_ovf", bus.overflow, 0);
                wait_end(T + 10, 1'b0);
                chk("job2_starts", starts_seen - s0, 1);

                // randomized jobs with random back-pressure and short gaps
                for (int j = 0; j < 3; j++) begin
                    n = $urandom_range(1, 24);
                    for (int i = 0; i < n; i++) begin
                        bus.sol_ready = 1'($urandom_range(0, 1));
                        send(8'($urandom));
                        gap = $urandom_range(0, T / 2);
                        repeat (gap) begin
                            bus.sol_ready = 1'($urandom_range(0, 1));
                            tick();
                        end
                    end
                    wait_end(4 * T + 200, 1'b1);
                end

                // byte lands exactly on the timeout cycle
                bus.sol_ready = 1'b1;
                s0 = starts_seen;
                send(8'h11);
                idle(T - 1);
                send(8'h22);
                chk("race_busy", bus.busy, 1);
                chk("race_no_end", bus.sol_end, 0);
                idle(3);
                chk("race_busy_later", bus.busy, 1);
                wait_end(T + 10, 1'b0);
                chk("race_latency", (end_cyc - last_rx_cyc >= T + 1) && (end_cyc - last_rx_cyc <= T + 3), 1'b1);
                chk("race_starts", starts_seen - s0, 1);

                // byte during drain rejoins the same job
                bus.sol_ready = 1'b0;
                s0 = starts_seen;
                send(8'h33);
                idle(T + 5);
                chk("drain_busy", bus.busy, 1);
                send(8'h44);
                chk("drain_rx_count", bus.byte_count, 2);
                idle(5);
                chk("drain_rx_busy", bus.busy, 1);
                bus.sol_ready = 1'b1;
                wait_end(T + 20, 1'b0);
                chk("drain_starts", starts_seen - s0, 1);

                // async reset in the middle of a job
                bus.sol_ready = 1'b0;
                send(8'h61);
                send(8'h62);
                send(8'h63);
                idle(2);
                #2;
                RST_N = 1'b0;
                #0.5;
                chk_all_zero("midreset");
                #0.5;
                RST_N = 1'b1;
                tick();
                chk("post_reset_valid", bus.sol_valid, 0);
                chk("post_reset_busy", bus.busy, 0);
                chk("post_reset_done", bus.done, 0);
                bus.sol_ready = 1'b1;
                idle(T + 10);
                s0 = starts_seen;
                send(8'h5A);
                wait_end(T + 10, 1'b0);
                chk("recover_starts", starts_seen - s0, 1);
                tick();
            end
        join_any
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
